// File: rtl/park_space_allocator.sv
// Parking-space allocator: per-space occupancy register, grant/reject on entry,
// release with error detection on exit, free-count and full/empty status.
module park_space_allocator #(
  parameter int N_SPACES = 8,
  parameter int IDX_W    = $clog2(N_SPACES),
  parameter int POLICY   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                entry_req,
  input  logic                exit_req,
  input  logic [IDX_W-1:0]    exit_space,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_space,
  output logic                reject,
  output logic                release_err,
  output logic [N_SPACES-1:0] occupancy,
  output logic [IDX_W:0]      free_count,
  output logic                full,
  output logic                empty
);

  localparam logic [IDX_W:0]   N_VAL    = (IDX_W+1)'(N_SPACES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPACES - 1);

  logic [N_SPACES-1:0] occ_q, occ_d;
  logic [IDX_W:0]      free_q, free_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    gs_q, gs_d;
  logic                gv_q, gv_d;
  logic                rej_q, rej_d;
  logic                rerr_q, rerr_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;

  logic [2*N_SPACES-1:0] rot_w;
  logic [IDX_W-1:0]      sel_lo, rr_off, sel_rr, sel;
  logic [IDX_W:0]        rr_sum;
  logic                  entry_act, exit_act, grant_ok, exit_in_range, exit_hit, exit_ok;

  // Index of the lowest zero bit; callers guarantee at least one zero exists.
  function automatic logic [IDX_W-1:0] lowest_free(input logic [N_SPACES-1:0] occ);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_SPACES - 1; i >= 0; i--) begin
      if (!occ[i[IDX_W-1:0]]) idx = i[IDX_W-1:0];
    end
    return idx;
  endfunction

  // Round-robin search: rotate occupancy so rr_q lands at bit 0, then find the
  // lowest free offset and map it back modulo N_SPACES.
  always_comb begin
    rot_w  = {occ_q, occ_q} >> rr_q;
    rr_off = lowest_free(rot_w[N_SPACES-1:0]);
    rr_sum = {1'b0, rr_q} + {1'b0, rr_off};
    if (rr_sum >= N_VAL) rr_sum = rr_sum - N_VAL;
    sel_rr = rr_sum[IDX_W-1:0];
    sel_lo = lowest_free(occ_q);
    sel    = (POLICY == 1) ? sel_rr : sel_lo;
  end

  always_comb begin
    exit_hit = 1'b0;
    for (int i = 0; i < N_SPACES; i++) begin
      if (exit_space == i[IDX_W-1:0]) exit_hit = occ_q[i[IDX_W-1:0]];
    end
  end

  assign entry_act     = enable & entry_req;
  assign exit_act      = enable & exit_req;
  assign grant_ok      = entry_act & ~full_q;
  assign exit_in_range = ({1'b0, exit_space} < N_VAL);
  assign exit_ok       = exit_act & exit_in_range & exit_hit;

  // Grant and exit never touch the same bit: grant picks a bit clear pre-edge,
  // exit only clears a bit set pre-edge.
  always_comb begin
    occ_d = occ_q;
    if (grant_ok) occ_d[sel] = 1'b1;
    if (exit_ok)  occ_d = occ_d & ~({{(N_SPACES-1){1'b0}}, 1'b1} << exit_space);

    free_d = free_q;
    case ({grant_ok, exit_ok})
      2'b10:   free_d = free_q - (IDX_W+1)'(1);
      2'b01:   free_d = free_q + (IDX_W+1)'(1);
      default: free_d = free_q;
    endcase

    full_d  = (free_d == '0);
    empty_d = (free_d == N_VAL);

    gv_d   = grant_ok;
    gs_d   = grant_ok ? sel : gs_q;
    rej_d  = entry_act & full_q;
    rerr_d = exit_act & ~exit_ok;

    rr_d = rr_q;
    if (POLICY == 1 && grant_ok) rr_d = (sel == LAST_IDX) ? '0 : sel + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q   <= '0;
      free_q  <= N_VAL;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      rr_q    <= '0;
      gv_q    <= 1'b0;
      gs_q    <= '0;
      rej_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      free_q  <= free_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      rr_q    <= rr_d;
      gv_q    <= gv_d;
      gs_q    <= gs_d;
      rej_q   <= rej_d;
      rerr_q  <= rerr_d;
    end
  end

  assign occupancy   = occ_q;
  assign free_count  = free_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign grant_valid = gv_q;
  assign grant_space = gs_q;
  assign reject      = rej_q;
  assign release_err = rerr_q;

endmodule

// File: tb/tb_park_space_allocator.sv
// Scoreboard bench: two 8-space allocators (lowest-first and round-robin)
// driven by directed vectors; a monitor pops expected pulses as they appear.
module tb_park_space_allocator;
  localparam int N  = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic en0, er0, xr0, en1, er1, xr1;
  logic [IW-1:0] xs0, xs1;
  logic gv0, rej0, rerr0, full0, empty0, gv1, rej1, rerr1, full1, empty1;
  logic [IW-1:0] gs0, gs1;
  logic [N-1:0] occ0, occ1;
  logic [IW:0] fc0, fc1;

  park_space_allocator #(.N_SPACES(N), .IDX_W(IW), .POLICY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .entry_req(er0), .exit_req(xr0),
    .exit_space(xs0), .grant_valid(gv0), .grant_space(gs0), .reject(rej0),
    .release_err(rerr0), .occupancy(occ0), .free_count(fc0), .full(full0), .empty(empty0));

  park_space_allocator #(.N_SPACES(N), .IDX_W(IW), .POLICY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .entry_req(er1), .exit_req(xr1),
    .exit_space(xs1), .grant_valid(gv1), .grant_space(gs1), .reject(rej1),
    .release_err(rerr1), .occupancy(occ1), .free_count(fc1), .full(full1), .empty(empty1));

  typedef struct packed {
    logic          gv;
    logic [IW-1:0] gs;
    logic          rej;
    logic          rerr;
  } pulse_t;

  pulse_t q0[$];
  pulse_t q1[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_p(input int d, input logic gv, input logic [IW-1:0] gs,
                          input logic rej, input logic rerr);
    pulse_t p;
    p.gv = gv; p.gs = gs; p.rej = rej; p.rerr = rerr;
    if (d == 0) q0.push_back(p);
    else        q1.push_back(p);
  endtask

  task automatic mon(input int d, input logic gv, input logic [IW-1:0] gs,
                     input logic rej, input logic rerr);
    pulse_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL dut%0d unexpected_pulse: got gv=%0b rej=%0b rerr=%0b expected none",
               d, gv, rej, rerr);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("dut%0d grant_valid", d), 32'(gv), 32'(e.gv));
      check($sformatf("dut%0d reject", d), 32'(rej), 32'(e.rej));
      check($sformatf("dut%0d release_err", d), 32'(rerr), 32'(e.rerr));
      if (e.gv) check($sformatf("dut%0d grant_space", d), 32'(gs), 32'(e.gs));
    end
  endtask

  always @(negedge clk) begin
    if ((gv0 | rej0 | rerr0) === 1'b1) mon(0, gv0, gs0, rej0, rerr0);
    if ((gv1 | rej1 | rerr1) === 1'b1) mon(1, gv1, gs1, rej1, rerr1);
  end

  task automatic idle();
    en0 = 1'b1; er0 = 1'b0; xr0 = 1'b0; xs0 = '0;
    en1 = 1'b1; er1 = 1'b0; xr1 = 1'b0; xs1 = '0;
  endtask

  task automatic drive(input int d, input logic en, input logic er, input logic xr,
                       input logic [IW-1:0] xs);
    if (d == 0) begin en0 = en; er0 = er; xr0 = xr; xs0 = xs; end
    else        begin en1 = en; er1 = er; xr1 = xr; xs1 = xs; end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk_state(input int d, input string tag, input logic [N-1:0] occ,
                           input int fc);
    check($sformatf("dut%0d %s occupancy", d, tag), 32'(d ? occ1 : occ0), 32'(occ));
    check($sformatf("dut%0d %s free_count", d, tag), 32'(d ? fc1 : fc0), 32'(fc));
    check($sformatf("dut%0d %s full", d, tag), 32'(d ? full1 : full0), 32'(fc == 0));
    check($sformatf("dut%0d %s empty", d, tag), 32'(d ? empty1 : empty0), 32'(fc == N));
  endtask

  task automatic chk_reset(input int d, input string tag);
    chk_state(d, tag, 8'h00, N);
    check($sformatf("dut%0d %s grant_valid", d, tag), 32'(d ? gv1 : gv0), 32'd0);
    check($sformatf("dut%0d %s grant_space", d, tag), 32'(d ? gs1 : gs0), 32'd0);
    check($sformatf("dut%0d %s reject", d, tag), 32'(d ? rej1 : rej0), 32'd0);
    check($sformatf("dut%0d %s release_err", d, tag), 32'(d ? rerr1 : rerr0), 32'd0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0, "reset");
    chk_reset(1, "reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Lowest-first: fill the lot, then reject the ninth car
    for (int i = 0; i < N; i++) begin
      expect_p(0, 1'b1, IW'(i), 1'b0, 1'b0);
      drive(0, 1'b1, 1'b1, 1'b0, 3'd0);
    end
    chk_state(0, "filled", 8'hFF, 0);
    expect_p(0, 1'b0, 3'd0, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0, 3'd0);
    chk_state(0, "reject_full", 8'hFF, 0);

    drive(0, 1'b1, 1'b0, 1'b1, 3'd3);
    chk_state(0, "exit3", 8'hF7, 1);
    expect_p(0, 1'b1, 3'd3, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0, 3'd0);
    chk_state(0, "regrant3", 8'hFF, 0);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd3);
    chk_state(0, "exit3_again", 8'hF7, 1);
    expect_p(0, 1'b0, 3'd0, 1'b0, 1'b1);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd3);
    chk_state(0, "double_exit", 8'hF7, 1);

    // Simultaneous entry/exit on a full lot, then with two free spaces
    expect_p(0, 1'b1, 3'd3, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0, 3'd0);
    expect_p(0, 1'b0, 3'd0, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b1, 3'd5);
    chk_state(0, "full_sim", 8'hDF, 1);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd0);
    chk_state(0, "exit0", 8'hDE, 2);
    expect_p(0, 1'b1, 3'd0, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b1, 3'd7);
    chk_state(0, "two_free_sim", 8'h5F, 2);

    drive(0, 1'b0, 1'b1, 1'b1, 3'd1);
    chk_state(0, "disabled", 8'h5F, 2);
    check("dut0 disabled grant_valid", 32'(gv0), 32'd0);

    // Build occupancy 0xA5, then reset with a pending entry
    expect_p(0, 1'b1, 3'd5, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0, 3'd0);
    expect_p(0, 1'b1, 3'd7, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0, 3'd0);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd1);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd3);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd4);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd6);
    chk_state(0, "pattern_a5", 8'hA5, 4);
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 3'd0);
    chk_reset(0, "reset_with_entry");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin: freed space 0 is skipped until the pointer wraps
    for (int i = 0; i < 3; i++) begin
      expect_p(1, 1'b1, IW'(i), 1'b0, 1'b0);
      drive(1, 1'b1, 1'b1, 1'b0, 3'd0);
    end
    drive(1, 1'b1, 1'b0, 1'b1, 3'd0);
    chk_state(1, "rr_exit0", 8'h06, 6);
    expect_p(1, 1'b1, 3'd3, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b1, 1'b0, 3'd0);
    chk_state(1, "rr_grant3", 8'h0E, 5);
    for (int i = 4; i < N; i++) begin
      expect_p(1, 1'b1, IW'(i), 1'b0, 1'b0);
      drive(1, 1'b1, 1'b1, 1'b0, 3'd0);
    end
    expect_p(1, 1'b1, 3'd0, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b1, 1'b0, 3'd0);
    chk_state(1, "rr_wrapped", 8'hFF, 0);
    expect_p(1, 1'b0, 3'd0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b1, 1'b0, 3'd0);
    drive(1, 1'b1, 1'b0, 1'b1, 3'd4);
    expect_p(1, 1'b1, 3'd4, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b1, 1'b0, 3'd0);
    chk_state(1, "rr_regrant4", 8'hFF, 0);

    @(negedge clk);
    #1;
    check("dut0 scoreboard_drained", 32'(q0.size()), 32'd0);
    check("dut1 scoreboard_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
